psk_symbol_mapper: RTL and testbench

Maps the bit stream emitted by the packetizer (AXIS, one symbol per beat, `tuser` = is_bpsk) onto signed I/Q constellation points for the PSK transmit chain. After every packet it appends a fixed run of zero-valued guard symbols so the downstream DUC/filter flushes cleanly. It sits directly downstream of the packetizer and upstream of the pulse-shaping filter, on the same slow symbol clock.

---
 rtl/psk_symbol_mapper_pkg.sv | 27 ++
 rtl/psk_const_lut.sv | 56 +++++
 rtl/psk_symbol_mapper.sv | 136 +++++++++++++
 tb/tb_psk_symbol_mapper.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psk_symbol_mapper_pkg.sv
// Shared definitions for the PSK symbol mapper: FSM states, Gray phase steps and
// the constellation sign convention.
package psk_symbol_mapper_pkg;

  typedef enum logic [0:0] {StRun, StTail} state_e;

  // A set data bit selects the negative half of its axis
  localparam logic NegBit = 1'b1;

  // Gray-coded dibit to phase step in quarter turns: 00->0, 01->1, 11->2, 10->3
  function automatic logic [1:0] gray_inc(input logic [1:0] bits);
    logic [1:0] step;
    unique case (bits)
      2'b00:   step = 2'd0;
      2'b01:   step = 2'd1;
      2'b11:   step = 2'd2;
      default: step = 2'd3;
    endcase
    return step;
  endfunction

  // Absolute phase to axis signs {q_neg, i_neg}: 0->(+,+) 1->(-,+) 2->(-,-) 3->(+,-)
  function automatic logic [1:0] phase_neg(input logic [1:0] phase);
    return {phase[1], phase[1] ^ phase[0]};
  endfunction

endpackage

// File: rtl/psk_const_lut.sv
// Combinational constellation lookup: (bits, is_bpsk[, phase]) -> {Q, I}.
// PSK_MAPPER_DIFF_EN adds the differential phase path.
module psk_const_lut
  import psk_symbol_mapper_pkg::*;
#(
  parameter int unsigned IQ_WIDTH = 12,
  parameter int unsigned AMP_BPSK = 2047,
  parameter int unsigned AMP_QPSK = 1448
) (
  input  logic [1:0]            bits,
  input  logic                  is_bpsk,
`ifdef PSK_MAPPER_DIFF_EN
  input  logic [1:0]            phase_in,
  output logic [1:0]            phase_out,
`endif
  output logic [2*IQ_WIDTH-1:0] iq
);

  localparam logic signed [IQ_WIDTH-1:0] AmpB = IQ_WIDTH'(AMP_BPSK);
  localparam logic signed [IQ_WIDTH-1:0] AmpQ = IQ_WIDTH'(AMP_QPSK);

  logic                       i_neg;
  logic                       q_neg;
  logic signed [IQ_WIDTH-1:0] amp_i;
  logic signed [IQ_WIDTH-1:0] i_val;
  logic signed [IQ_WIDTH-1:0] q_val;

`ifdef PSK_MAPPER_DIFF_EN
  logic [1:0] phase_nxt;
  logic [1:0] signs;

  always_comb begin
    phase_nxt = is_bpsk ? {phase_in[1] ^ bits[0], phase_in[0]} : phase_in + gray_inc(bits);
    signs     = phase_neg(phase_nxt);
    // BPSK only ever looks at the half-turn bit of the phase
    i_neg     = is_bpsk ? phase_nxt[1] : signs[0];
    q_neg     = signs[1];
  end

  assign phase_out = phase_nxt;
`else
  always_comb begin
    i_neg = is_bpsk ? (bits[0] == NegBit) : (bits[1] == NegBit);
    q_neg = (bits[0] == NegBit);
  end
`endif

  always_comb begin
    amp_i = is_bpsk ? AmpB : AmpQ;
    i_val = i_neg ? -amp_i : amp_i;
    q_val = is_bpsk ? '0 : (q_neg ? -AmpQ : AmpQ);
  end

  assign iq = {q_val, i_val};

endmodule

// File: rtl/psk_symbol_mapper.sv
// AXIS PSK symbol mapper with a registered output slice and a zero-symbol guard tail.
// Define PSK_MAPPER_DIFF_EN for differential encoding.
module psk_symbol_mapper
  import psk_symbol_mapper_pkg::*;
#(
  parameter int unsigned BYTES      = 1,
  parameter int unsigned IQ_WIDTH   = 12,
  parameter int unsigned AMP_BPSK   = 2047,
  parameter int unsigned AMP_QPSK   = 1448,
  parameter int unsigned TAIL_SYMBS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BYTES*8-1:0]    S_tdata,
  input  logic                  S_tvalid,
  output logic                  S_tready,
  input  logic                  S_tlast,
  input  logic                  S_tuser,
  output logic [2*IQ_WIDTH-1:0] M_tdata,
  output logic                  M_tvalid,
  input  logic                  M_tready,
  output logic                  M_tlast,
  output logic                  M_tuser,
  output logic                  busy
);

  localparam logic [7:0] TailLoad = 8'(TAIL_SYMBS);
  localparam logic       HasTail  = (TAIL_SYMBS != 0);

  state_e                state_q;
  logic [7:0]            tail_cnt_q;
  logic                  en_q;
  logic                  in_fire;
  logic                  out_fire;
  logic [2*IQ_WIDTH-1:0] lut_iq;
  logic                  unused_tdata;

  assign unused_tdata = ^S_tdata[BYTES*8-1:2];

  // en_q keeps S_tready low while in reset and for the first cycle after it
  assign S_tready = en_q && (state_q == StRun) && (!M_tvalid || M_tready);
  assign in_fire  = S_tvalid && S_tready;
  assign out_fire = M_tvalid && M_tready;

`ifdef PSK_MAPPER_DIFF_EN
  logic [1:0] phase_q;
  logic [1:0] lut_phase;
  logic       mid_pkt_q;

  psk_const_lut #(
    .IQ_WIDTH (IQ_WIDTH),
    .AMP_BPSK (AMP_BPSK),
    .AMP_QPSK (AMP_QPSK)
  ) u_lut (
    .bits      (S_tdata[1:0]),
    .is_bpsk   (S_tuser),
    .phase_in  (mid_pkt_q ? phase_q : 2'b00),
    .phase_out (lut_phase),
    .iq        (lut_iq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= 2'b00;
      mid_pkt_q <= 1'b0;
    end else if (in_fire) begin
      phase_q   <= lut_phase;
      mid_pkt_q <= !S_tlast;
    end
  end
`else
  psk_const_lut #(
    .IQ_WIDTH (IQ_WIDTH),
    .AMP_BPSK (AMP_BPSK),
    .AMP_QPSK (AMP_QPSK)
  ) u_lut (
    .bits    (S_tdata[1:0]),
    .is_bpsk (S_tuser),
    .iq      (lut_iq)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      tail_cnt_q <= '0;
      en_q       <= 1'b0;
      M_tdata    <= '0;
      M_tvalid   <= 1'b0;
      M_tlast    <= 1'b0;
      M_tuser    <= 1'b1;
      busy       <= 1'b0;
    end else begin
      en_q <= 1'b1;
      // A new packet starting on the drain cycle of the previous one keeps busy set
      if (in_fire) begin
        busy <= 1'b1;
      end else if (out_fire && M_tlast) begin
        busy <= 1'b0;
      end

      unique case (state_q)
        StRun: begin
          if (in_fire) begin
            M_tdata  <= lut_iq;
            M_tvalid <= 1'b1;
            M_tuser  <= S_tuser;
            M_tlast  <= HasTail ? 1'b0 : S_tlast;
            if (S_tlast && HasTail) begin
              state_q    <= StTail;
              tail_cnt_q <= TailLoad;
            end
          end else if (M_tready) begin
            M_tvalid <= 1'b0;
          end
        end
        StTail: begin
          if (out_fire) begin
            if (tail_cnt_q != 8'd0) begin
              M_tdata    <= '0;
              M_tuser    <= 1'b1;
              M_tlast    <= (tail_cnt_q == 8'd1);
              tail_cnt_q <= tail_cnt_q - 8'd1;
            end else begin
              M_tvalid <= 1'b0;
              M_tlast  <= 1'b0;
              state_q  <= StRun;
            end
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_psk_symbol_mapper.sv
// Randomized bench for psk_symbol_mapper against a behavioural constellation/packet model,
// plus directed literal checks and a TAIL_SYMBS = 0 instance.
module tb_psk_symbol_mapper;

  localparam int IQ   = 12;
  localparam int TAIL = 8;
  localparam int AB   = 2047;
  localparam int AQ   = 1448;

  typedef struct {
    int i;
    int q;
    bit user;
    bit last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    S_tdata;
  logic          S_tvalid, S_tready, S_tlast, S_tuser;
  logic [2*IQ-1:0] M_tdata;
  logic          M_tvalid, M_tready, M_tlast, M_tuser, busy;

  logic [7:0]    s0_tdata;
  logic          s0_tvalid, s0_tready, s0_tlast, s0_tuser;
  logic [2*IQ-1:0] m0_tdata;
  logic          m0_tvalid, m0_tready, m0_tlast, m0_tuser, busy0;

  int vectors = 0;
  int errs    = 0;

  beat_t exp_q[$];
  int    got_i[$];
  int    got_q[$];
  int    got_u[$];
  int    got_l[$];
  int    m_phase = 0;
  bit    m_mid   = 0;
  bit    mbusy   = 0;
  bit    m_tail  = 0;
  bit    hold_v  = 0;
  bit    lat_v   = 0;
  logic [2*IQ-1:0] hold_data;
  logic  hold_last, hold_user;
  int    rdy_mode = 0;
  int    pidx     = 0;
  int    pat[4]   = '{1, 0, 0, 1};

  always #5 clk = ~clk;

  psk_symbol_mapper #(.TAIL_SYMBS(TAIL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .S_tdata  (S_tdata),
    .S_tvalid (S_tvalid),
    .S_tready (S_tready),
    .S_tlast  (S_tlast),
    .S_tuser  (S_tuser),
    .M_tdata  (M_tdata),
    .M_tvalid (M_tvalid),
    .M_tready (M_tready),
    .M_tlast  (M_tlast),
    .M_tuser  (M_tuser),
    .busy     (busy)
  );

  psk_symbol_mapper #(.TAIL_SYMBS(0)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .S_tdata  (s0_tdata),
    .S_tvalid (s0_tvalid),
    .S_tready (s0_tready),
    .S_tlast  (s0_tlast),
    .S_tuser  (s0_tuser),
    .M_tdata  (m0_tdata),
    .M_tvalid (m0_tvalid),
    .M_tready (m0_tready),
    .M_tlast  (m0_tlast),
    .M_tuser  (m0_tuser),
    .busy     (busy0)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: what the packet stream must look like, computed from the mapping rules
  function automatic void model_accept(input logic [1:0] d, input logic u, input logic l);
    beat_t b;
    int    isg, qsg;
`ifdef PSK_MAPPER_DIFF_EN
    int    gstep[4] = '{0, 1, 3, 2};
    if (!m_mid) m_phase = 0;
    if (u) m_phase = (m_phase + 2 * int'(d[0])) % 4;
    else   m_phase = (m_phase + gstep[d]) % 4;
    if (u) isg = (m_phase >= 2) ? -1 : 1;
    else   isg = (m_phase == 1 || m_phase == 2) ? -1 : 1;
    qsg   = (m_phase >= 2) ? -1 : 1;
    m_mid = !l;
`else
    isg = u ? (d[0] ? -1 : 1) : (d[1] ? -1 : 1);
    qsg = d[0] ? -1 : 1;
`endif
    b.i    = isg * (u ? AB : AQ);
    b.q    = u ? 0 : qsg * AQ;
    b.user = u;
    b.last = l && (TAIL == 0);
    exp_q.push_back(b);
    if (l && TAIL > 0) begin
      for (int k = 0; k < TAIL; k++) begin
        b.i = 0; b.q = 0; b.user = 1'b1; b.last = (k == TAIL - 1);
        exp_q.push_back(b);
      end
    end
  endfunction

  // Handshakes are sampled on the falling edge; they complete on the next rising edge
  always @(negedge clk) begin : monitor
    beat_t e;
    bit    out_f, in_f;
    if (!rst_n) begin
      exp_q.delete();
      m_phase = 0; m_mid = 0; mbusy = 0; m_tail = 0; hold_v = 0; lat_v = 0;
    end else begin
      chk("busy", int'(busy), int'(mbusy));
      if (lat_v) chk("latency_valid", int'(M_tvalid), 1);
      if (hold_v) begin
        chk("hold_valid", int'(M_tvalid), 1);
        chk("hold_data", int'(M_tdata), int'(hold_data));
        chk("hold_last", int'(M_tlast), int'(hold_last));
        chk("hold_user", int'(M_tuser), int'(hold_user));
      end
      if (M_tvalid && !M_tready) chk("s_tready_stall", int'(S_tready), 0);
      if (m_tail) chk("s_tready_tail", int'(S_tready), 0);
      out_f = M_tvalid && M_tready;
      in_f  = S_tvalid && S_tready;
      if (out_f) begin
        chk("beat_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_i", $signed(M_tdata[IQ-1:0]), e.i);
          chk("out_q", $signed(M_tdata[2*IQ-1:IQ]), e.q);
          chk("out_user", int'(M_tuser), int'(e.user));
          chk("out_last", int'(M_tlast), int'(e.last));
        end
        got_i.push_back($signed(M_tdata[IQ-1:0]));
        got_q.push_back($signed(M_tdata[2*IQ-1:IQ]));
        got_u.push_back(int'(M_tuser));
        got_l.push_back(int'(M_tlast));
        if (M_tlast) begin
          mbusy  = 0;
          m_tail = 0;
        end
      end
      if (in_f) begin
        model_accept(S_tdata[1:0], S_tuser, S_tlast);
        mbusy = 1;
        if (S_tlast && TAIL > 0) m_tail = 1;
      end
      hold_v    = M_tvalid && !M_tready;
      hold_data = M_tdata;
      hold_last = M_tlast;
      hold_user = M_tuser;
      lat_v     = in_f;
    end
  end

  initial begin : ready_gen
    M_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       M_tready = 1'b1;
        1:       M_tready = ($urandom % 4) != 0;
        default: begin
          M_tready = pat[pidx] != 0;
          pidx     = (pidx + 1) % 4;
        end
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat was taken
  task automatic send(input logic [1:0] d, input logic u, input logic l);
    S_tdata  = {6'b0, d};
    S_tuser  = u;
    S_tlast  = l;
    S_tvalid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (S_tready) begin
        @(posedge clk);
        #1;
        S_tvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("send_timeout", int'(S_tready), 1);
    S_tvalid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !M_tvalid) done = 1;
    end
    if (!done) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_i.delete(); got_q.delete(); got_u.delete(); got_l.delete();
  endtask

  initial begin : main
    int bp_i[4];
    int qp_i[4];
    int qp_q[4];
    int len;
    int nb;
`ifdef PSK_MAPPER_DIFF_EN
    bp_i = '{AB, -AB, AB, AB};
    qp_i = '{AQ, -AQ, AQ, -AQ};
    qp_q = '{AQ, AQ, -AQ, -AQ};
`else
    bp_i = '{AB, -AB, -AB, AB};
    qp_i = '{AQ, AQ, -AQ, -AQ};
    qp_q = '{AQ, -AQ, -AQ, AQ};
`endif
    rst_n = 1'b0;
    S_tdata = '0; S_tvalid = 1'b0; S_tlast = 1'b0; S_tuser = 1'b0;
    s0_tdata = '0; s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tuser = 1'b0; m0_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tdata", int'(M_tdata), 0);
    chk("rst_tvalid", int'(M_tvalid), 0);
    chk("rst_tlast", int'(M_tlast), 0);
    chk("rst_tuser", int'(M_tuser), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_s_tready", int'(S_tready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // TAIL_SYMBS = 0: single BPSK beat with tlast
    s0_tdata = 8'h01; s0_tuser = 1'b1; s0_tlast = 1'b1; s0_tvalid = 1'b1;
    nb = 0;
    for (int n = 0; n < 20 && nb == 0; n++) begin
      @(negedge clk);
      if (s0_tready) nb = 1;
      @(posedge clk);
      #1;
    end
    chk("t0_accepted", nb, 1);
    s0_tvalid = 1'b0;
    @(negedge clk);
    chk("t0_valid", int'(m0_tvalid), 1);
    chk("t0_last", int'(m0_tlast), 1);
    chk("t0_i", $signed(m0_tdata[IQ-1:0]), -AB);
    chk("t0_busy_high", int'(busy0), 1);
    nb = 0;
    repeat (4) begin
      @(negedge clk);
      if (m0_tvalid) nb++;
    end
    chk("t0_extra_beats", nb, 0);
    chk("t0_busy_low", int'(busy0), 0);
    @(posedge clk);
    #1;

    // BPSK 0,1,1,0 with guard tail
    rdy_mode = 0;
    clear_log();
    send(2'b00, 1'b1, 1'b0);
    send(2'b01, 1'b1, 1'b0);
    send(2'b01, 1'b1, 1'b0);
    send(2'b00, 1'b1, 1'b1);
    drain();
    chk("bpsk_beats", got_i.size(), 4 + TAIL);
    for (int k = 0; k < 4 + TAIL && k < got_i.size(); k++) begin
      chk("bpsk_lit_i", got_i[k], (k < 4) ? bp_i[k] : 0);
      chk("bpsk_lit_q", got_q[k], 0);
      chk("bpsk_lit_last", got_l[k], (k == 3 + TAIL) ? 1 : 0);
    end

    // QPSK 00,01,11,10
    clear_log();
    send(2'b00, 1'b0, 1'b0);
    send(2'b01, 1'b0, 1'b0);
    send(2'b11, 1'b0, 1'b0);
    send(2'b10, 1'b0, 1'b1);
    drain();
    chk("qpsk_beats", got_i.size(), 4 + TAIL);
    for (int k = 0; k < 4 && k < got_i.size(); k++) begin
      chk("qpsk_lit_i", got_i[k], qp_i[k]);
      chk("qpsk_lit_q", got_q[k], qp_q[k]);
      chk("qpsk_lit_user", got_u[k], 0);
    end

    // Stall pattern 1,0,0,1 on M_tready during payload
    rdy_mode = 2;
    clear_log();
    for (int k = 0; k < 6; k++) send(2'(k), 1'b0, k == 5);
    drain();
    chk("stall_beats", got_i.size(), 6 + TAIL);

    // Randomized packets, mixed modes, random back-pressure and gaps
    for (int p = 0; p < 25; p++) begin
      rdy_mode = $urandom_range(0, 2);
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        send(2'($urandom % 4), 1'($urandom % 2), k == len - 1);
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();

`ifdef PSK_MAPPER_DIFF_EN
    rdy_mode = 0;
    clear_log();
    send(2'b01, 1'b1, 1'b0);
    send(2'b01, 1'b1, 1'b0);
    send(2'b00, 1'b1, 1'b1);
    send(2'b01, 1'b1, 1'b1);
    drain();
    chk("diff_beats", got_i.size(), 4 + 2 * TAIL);
    if (got_i.size() > 3 + TAIL) begin
      chk("diff_i0", got_i[0], -AB);
      chk("diff_i1", got_i[1], AB);
      chk("diff_i2", got_i[2], AB);
      chk("diff_restart", got_i[3 + TAIL], -AB);
    end
`endif

    // Reset asserted during the guard tail
    rdy_mode = 0;
    send(2'b00, 1'b1, 1'b0);
    send(2'b01, 1'b1, 1'b0);
    send(2'b00, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_tail_valid", int'(M_tvalid), 0);
    chk("rst_tail_last", int'(M_tlast), 0);
    chk("rst_tail_busy", int'(busy), 0);
    chk("rst_tail_s_tready", int'(S_tready), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    send(2'b10, 1'b0, 1'b0);
    send(2'b01, 1'b0, 1'b1);
    drain();
    chk("post_rst_beats", got_i.size(), 2 + TAIL);
    if (got_i.size() > 0) chk("post_rst_first_user", got_u[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
